fcc_point_streamer: RTL and testbench
=====================================

# fcc_point_streamer

Frame-buffered point transmitter feeding the fixed-column clustering core's point input. A host loads one ROWS×COLS frame of (x, y, z, ground) samples into internal RAM; on `start` the block streams every cell in raster order (row-major, col fastest) over a valid/ready interface, one point per cycle under no backpressure, then pulses `done`. It sits between the sensor/host loader and the clustering top's `in_*` port.

## Interface
- `W`, 16, signed coordinate width
- `ROWS`, 30, rows per frame
- `COLS`, 30, columns per row
- `ROW_W`, 8, row index width
- `COL_W`, 5, column index width
- `GROUND_Z`, -16'sd100, signed ground threshold (used only with `FCC_STREAM_GROUND_CLASSIFY_EN`)

- `clk`  in  1  clock; reset `rst`, synchronous, active-high
- `rst`  in  1  synchronous active-high reset
- `ld_we`  in  1  load strobe, one cell per cycle
- `ld_row`  in  ROW_W  load row
- `ld_col`  in  COL_W  load column
- `ld_x`, `ld_y`, `ld_z`  in  W each  signed coordinates
- `ld_is_ground`  in  1  stored ground flag
- `start`  in  1  single-cycle stream request
- `busy`  out  1  streaming in progress
- `done`  out  1  one-cycle pulse after final point accepted
- `out_valid`  out  1  point available
- `out_ready`  in  1  sink accepts point
- `out_row`  out  ROW_W, `out_col`  out  COL_W  point index
- `out_x`, `out_y`, `out_z`  out  W each  coordinates
- `out_is_ground`  out  1  ground flag

## Operation
- RAM: ROWS·COLS entries of {x,y,z,g}, address row·COLS+col, synchronous read (1-cycle latency); contents not cleared by reset.
- Load: write when `ld_we && !busy && ld_row<ROWS && ld_col<COLS`; out-of-range or busy writes silently dropped.
- FSM IDLE → PRIME → STREAM → IDLE.
  - IDLE: `start` (with `!busy`) resets read pointer to (0,0), issues read, enters PRIME.
  - PRIME: RAM data lands in output register; `out_valid`=1; read of next cell issued; enter STREAM.
  - STREAM: read-ahead with 2-entry skid buffer (output reg + holding reg). On handshake (`out_valid && out_ready`) advance output from skid; issue next read whenever skid will have space. Read pointer: col increments; col==COLS-1 wraps to 0 and row increments; stops issuing after (ROWS-1, COLS-1).
  - Handshake on cell (ROWS-1, COLS-1): next cycle `out_valid`=0, `busy`=0, `done`=1 for one cycle, FSM → IDLE.
- Payload stable while `out_valid && !out_ready`; `out_valid` never drops without a handshake.
- `start` while busy ignored; `start` in same cycle as final handshake ignored.
- `rst` mid-stream: FSM → IDLE, skid emptied, all outputs to reset values next cycle; RAM preserved.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_row`=0, `out_col`=0, `out_x/y/z`=0, `out_is_ground`=0.
- `start` at cycle T → `busy`=1 at T+1, first `out_valid` at T+2 carrying (0,0).
- `out_ready` held high: one point per cycle, ROWS·COLS consecutive valid cycles, `done` at T+2+ROWS·COLS.
- `out_ready` deassertion for any number of cycles causes no loss, duplication, or reordering; resumes at full rate the cycle ready returns.
- Load-to-stream: a write at cycle T is visible to a stream started at T+1.

## Configuration
- `FCC_STREAM_GROUND_CLASSIFY_EN` defined: `out_is_ground` = (`out_z` <= `GROUND_Z`, signed compare), stored `ld_is_ground` ignored, comparison registered with payload (no added latency).
- Undefined: `out_is_ground` = stored `ld_is_ground` bit; `GROUND_Z` unused.

## Test plan
- Load all 900 cells with x=row, y=col, z=row·COLS+col, g=col[0]; `start`, `out_ready`=1 → 900 points in raster order on consecutive cycles, first at start+2, `done` pulse at start+902, `busy` low same cycle.
- Same frame, `out_ready` random 50% → identical 900-point sequence, payload stable on every stalled cycle, no gaps caused beyond stalls.
- `ld_we` with row=30 col=5 and with row=3 col=31 → no RAM change; `ld_we` while busy → dropped, streamed data unchanged.
- `rst` asserted at point 417 mid-stream → next cycle `out_valid`=0, `busy`=0, no `done`; re-`start` streams full frame from (0,0) with preserved data.
- `start` pulses during stream and on final-handshake cycle → ignored; exactly one `done` per accepted start.
- With macro: cell z=-100 → `out_is_ground`=1, z=-99 → 0 regardless of stored flag; without macro: stored flag reproduced.

Source files
------------

// File: rtl/fcc_point_streamer_if.sv
// rtl/fcc_point_streamer_if.sv - load/start/point-stream bundle for fcc_point_streamer
//
// Purpose: groups the host load port, the stream control and the outbound
// point stream of fcc_point_streamer.
//
// Modports:
//   slave  - streamer side: receives ld_*, start, out_ready;
//            drives busy, done, out_valid, out_row/col, out_x/y/z, out_is_ground
//   master - host/sink side: the mirror image of slave
interface fcc_point_streamer_if #(
    parameter int W     = 16,
    parameter int ROW_W = 8,
    parameter int COL_W = 5
);
    logic                    ld_we;
    logic [ROW_W-1:0]        ld_row;
    logic [COL_W-1:0]        ld_col;
    logic signed [W-1:0]     ld_x;
    logic signed [W-1:0]     ld_y;
    logic signed [W-1:0]     ld_z;
    logic                    ld_is_ground;

    logic                    start;
    logic                    busy;
    logic                    done;

    logic                    out_valid;
    logic                    out_ready;
    logic [ROW_W-1:0]        out_row;
    logic [COL_W-1:0]        out_col;
    logic signed [W-1:0]     out_x;
    logic signed [W-1:0]     out_y;
    logic signed [W-1:0]     out_z;
    logic                    out_is_ground;

    modport slave (
        input  ld_we, ld_row, ld_col, ld_x, ld_y, ld_z, ld_is_ground,
        input  start, out_ready,
        output busy, done,
        output out_valid, out_row, out_col, out_x, out_y, out_z, out_is_ground
    );

    modport master (
        output ld_we, ld_row, ld_col, ld_x, ld_y, ld_z, ld_is_ground,
        output start, out_ready,
        input  busy, done,
        input  out_valid, out_row, out_col, out_x, out_y, out_z, out_is_ground
    );
endinterface

// File: rtl/fcc_point_streamer.sv
// rtl/fcc_point_streamer.sv - frame-buffered raster point transmitter
//
// Purpose: holds one ROWS x COLS frame of {x, y, z, ground} samples loaded by
// the host and, on start, streams every cell in row-major order over a
// valid/ready port, then pulses done.
//
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset (frame RAM is not cleared)
//   pt_io  - fcc_point_streamer_if.slave: ld_* load port, start/busy/done,
//            out_* point stream with out_valid/out_ready handshake
//
// Optional feature macro: FCC_STREAM_GROUND_CLASSIFY_EN
//   defined   - out_is_ground = (out_z <= GROUND_Z), stored flag ignored
//   undefined - out_is_ground = stored ld_is_ground bit
module fcc_point_streamer #(
    parameter int                     W        = 16,
    parameter int                     ROWS     = 30,
    parameter int                     COLS     = 30,
    parameter int                     ROW_W    = 8,
    parameter int                     COL_W    = 5,
    parameter logic signed [W-1:0]    GROUND_Z = -16'sd100
) (
    input  logic                 clk,
    input  logic                 rst,
    fcc_point_streamer_if.slave  pt_io
);
    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW    = 3 * W + 1;                // {x, y, z, g}

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Frame RAM and its registered read port
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Read-side bookkeeping: rvalid_q marks that rdata_q holds a cell this cycle
    logic             rvalid_q, rvalid_d;
    logic [ROW_W-1:0] rrow_q, rrow_d;
    logic [COL_W-1:0] rcol_q, rcol_d;

    // Read pointer for the next cell to fetch
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [ROW_W-1:0] rd_row_q, rd_row_d;
    logic [COL_W-1:0] rd_col_q, rd_col_d;
    logic             more_q, more_d;

    // Two-entry skid: output register plus holding register
    logic             out_valid_q, out_valid_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic [DW-1:0]    out_data_q, out_data_d;

    logic             hold_valid_q, hold_valid_d;
    logic [ROW_W-1:0] hold_row_q, hold_row_d;
    logic [COL_W-1:0] hold_col_q, hold_col_d;
    logic [DW-1:0]    hold_data_q, hold_data_d;

    logic             done_q, done_d;

    logic             hs;
    logic             last_hs;
    logic             start_go;
    logic             issue;
    logic [1:0]       occ;
    logic [AW-1:0]    iss_addr;
    logic [ROW_W-1:0] iss_row;
    logic [COL_W-1:0] iss_col;

    logic             ld_ok;
    logic [AW-1:0]    ld_addr;

    // The ground flag is resolved as a cell enters the output register, so the
    // classification travels with the payload and adds no latency.
    function automatic logic [DW-1:0] classify(input logic [DW-1:0] d);
`ifdef FCC_STREAM_GROUND_CLASSIFY_EN
        classify = {d[DW-1:1], ($signed(d[W:1]) <= GROUND_Z)};
`else
        classify = d;
`endif
    endfunction

`ifndef FCC_STREAM_GROUND_CLASSIFY_EN
    logic unused_ground_z;
    assign unused_ground_z = ^GROUND_Z;
`endif

    // ------------------------------------------------------------------
    // Load port and frame RAM
    // ------------------------------------------------------------------
    assign ld_ok   = pt_io.ld_we && (state_q == S_IDLE)
                     && (32'(pt_io.ld_row) < ROWS) && (32'(pt_io.ld_col) < COLS);
    assign ld_addr = AW'(32'(pt_io.ld_row) * COLS + 32'(pt_io.ld_col));

    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_addr] <= {pt_io.ld_x, pt_io.ld_y, pt_io.ld_z, pt_io.ld_is_ground};
        end
        if (issue) begin
            rdata_q <= mem[iss_addr];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pt_io.start) state_d = S_PRIME;
            S_PRIME:  state_d = S_STREAM;
            S_STREAM: if (last_hs) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        pt_io.busy          = (state_q != S_IDLE);
        pt_io.done          = done_q;
        pt_io.out_valid     = out_valid_q;
        pt_io.out_row       = out_row_q;
        pt_io.out_col       = out_col_q;
        pt_io.out_x         = out_data_q[DW-1 -: W];
        pt_io.out_y         = out_data_q[2*W -: W];
        pt_io.out_z         = out_data_q[W -: W];
        pt_io.out_is_ground = out_data_q[0];
    end

    // ------------------------------------------------------------------
    // Datapath: skid advance and read-ahead
    // ------------------------------------------------------------------
    always_comb begin
        hs      = out_valid_q && pt_io.out_ready;
        last_hs = hs && (out_row_q == LAST_ROW) && (out_col_q == LAST_COL);
        done_d  = last_hs;

        // Cells that will still be buffered after this edge, before any new
        // read lands. A new read may only be issued if it will find room next
        // cycle even if the sink stalls then.
        occ = {1'b0, out_valid_q} + {1'b0, hold_valid_q} + {1'b0, rvalid_q}
              - {1'b0, hs};

        out_valid_d  = out_valid_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_data_d   = out_data_q;
        hold_valid_d = hold_valid_q;
        hold_row_d   = hold_row_q;
        hold_col_d   = hold_col_q;
        hold_data_d  = hold_data_q;

        if (hs || !out_valid_q) begin
            // Output slot frees up: pull the oldest buffered cell forward.
            if (hold_valid_q) begin
                out_valid_d  = 1'b1;
                out_row_d    = hold_row_q;
                out_col_d    = hold_col_q;
                out_data_d   = hold_data_q;
                hold_valid_d = rvalid_q;
                hold_row_d   = rrow_q;
                hold_col_d   = rcol_q;
                hold_data_d  = classify(rdata_q);
            end else if (rvalid_q) begin
                out_valid_d  = 1'b1;
                out_row_d    = rrow_q;
                out_col_d    = rcol_q;
                out_data_d   = classify(rdata_q);
                hold_valid_d = 1'b0;
            end else begin
                out_valid_d  = 1'b0;
                hold_valid_d = 1'b0;
            end
        end else if (!hold_valid_q && rvalid_q) begin
            // Stalled: park the arriving cell in the holding register.
            hold_valid_d = 1'b1;
            hold_row_d   = rrow_q;
            hold_col_d   = rcol_q;
            hold_data_d  = classify(rdata_q);
        end

        start_go = (state_q == S_IDLE) && pt_io.start;
        issue    = start_go || ((state_q != S_IDLE) && more_q && (occ <= 2'd1));
        iss_addr = start_go ? '0 : rd_addr_q;
        iss_row  = start_go ? '0 : rd_row_q;
        iss_col  = start_go ? '0 : rd_col_q;

        rd_addr_d = rd_addr_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        more_d    = more_q;
        if (issue) begin
            rd_addr_d = iss_addr + AW'(1);
            if (iss_col == LAST_COL) begin
                rd_col_d = '0;
                rd_row_d = iss_row + ROW_W'(1);
            end else begin
                rd_col_d = iss_col + COL_W'(1);
                rd_row_d = iss_row;
            end
            more_d = !((iss_row == LAST_ROW) && (iss_col == LAST_COL));
        end

        rvalid_d = issue;
        rrow_d   = iss_row;
        rcol_d   = iss_col;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q     <= 1'b0;
            rrow_q       <= '0;
            rcol_q       <= '0;
            rd_addr_q    <= '0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
            more_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_data_q   <= '0;
            hold_valid_q <= 1'b0;
            hold_row_q   <= '0;
            hold_col_q   <= '0;
            hold_data_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            rvalid_q     <= rvalid_d;
            rrow_q       <= rrow_d;
            rcol_q       <= rcol_d;
            rd_addr_q    <= rd_addr_d;
            rd_row_q     <= rd_row_d;
            rd_col_q     <= rd_col_d;
            more_q       <= more_d;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_data_q   <= out_data_d;
            hold_valid_q <= hold_valid_d;
            hold_row_q   <= hold_row_d;
            hold_col_q   <= hold_col_d;
            hold_data_q  <= hold_data_d;
            done_q       <= done_d;
        end
    end
endmodule

// File: tb/tb_fcc_point_streamer.sv
// tb/tb_fcc_point_streamer.sv - directed self-checking bench for fcc_point_streamer
module tb_fcc_point_streamer;
    localparam int W     = 16;
    localparam int ROWS  = 30;
    localparam int COLS  = 30;
    localparam int ROW_W = 8;
    localparam int COL_W = 5;
    localparam int N     = ROWS * COLS;
    localparam int PW    = ROW_W + COL_W + 3 * W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fcc_point_streamer_if #(.W(W), .ROW_W(ROW_W), .COL_W(COL_W)) bus();

    fcc_point_streamer #(
        .W(W), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
        .GROUND_Z(-16'sd100)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .pt_io (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [W-1:0] mx [N];
    logic signed [W-1:0] my [N];
    logic signed [W-1:0] mz [N];
    logic                mg [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] exp_payload(input int k);
        logic g;
`ifdef FCC_STREAM_GROUND_CLASSIFY_EN
        g = (mz[k] <= -16'sd100);
`else
        g = mg[k];
`endif
        return {ROW_W'(k / COLS), COL_W'(k % COLS), mx[k], my[k], mz[k], g};
    endfunction

    function automatic logic [PW-1:0] got_payload();
        return {bus.out_row, bus.out_col, bus.out_x, bus.out_y, bus.out_z, bus.out_is_ground};
    endfunction

    // Drives one load strobe; called right after a falling edge.
    task automatic load(input int r, input int c, input logic signed [W-1:0] x,
                        input logic signed [W-1:0] y, input logic signed [W-1:0] z,
                        input logic g);
        bus.ld_we        = 1'b1;
        bus.ld_row       = ROW_W'(r);
        bus.ld_col       = COL_W'(c);
        bus.ld_x         = x;
        bus.ld_y         = y;
        bus.ld_z         = z;
        bus.ld_is_ground = g;
        @(negedge clk);
        bus.ld_we        = 1'b0;
    endtask

    // Raises a garbage write for one cycle without waiting (cleared by the caller loop).
    task automatic load_nowait(input int r, input int c);
        bus.ld_we        = 1'b1;
        bus.ld_row       = ROW_W'(r);
        bus.ld_col       = COL_W'(c);
        bus.ld_x         = 16'h5a5a;
        bus.ld_y         = 16'h5a5a;
        bus.ld_z         = 16'h5a5a;
        bus.ld_is_ground = 1'b1;
    endtask

    // mode 0: ready always high; mode 1: random ready.
    // abort_at >= 0: assert rst while point abort_at is presented.
    // pulses: start pulses mid-stream and on the final handshake, plus a busy write.
    task automatic stream(input int mode, input int abort_at, input bit pulses);
        int k;
        int cyc;
        logic [PW-1:0] got;
        logic [PW-1:0] exp;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_at_t1", bus.busy, 1'b1);
        chk("valid_at_t1", bus.out_valid, 1'b0);
        k   = 0;
        cyc = 1;
        while (k < N && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            bus.ld_we = 1'b0;
            chk("valid_no_gap", bus.out_valid, 1'b1);
            chk("done_early", bus.done, 1'b0);
            got = got_payload();
            exp = exp_payload(k);
            chk("payload", got, exp);
            if (abort_at == k) begin
                rst           = 1'b1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_valid", bus.out_valid, 1'b0);
                chk("abort_busy", bus.busy, 1'b0);
                chk("abort_done", bus.done, 1'b0);
                got = got_payload();
                chk("abort_payload", got, {PW{1'b0}});
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("abort_no_done", bus.done, 1'b0);
                    chk("abort_idle", bus.busy, 1'b0);
                end
                return;
            end
            bus.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (pulses && k == 100) begin
                bus.start = 1'b1;
                load_nowait(ROWS - 1, COLS - 1);
            end
            if (pulses && k == N - 1 && bus.out_ready) bus.start = 1'b1;
            if (bus.out_ready) k++;
        end
        chk("stream_timeout", k, N);
        @(negedge clk);
        cyc++;
        bus.start = 1'b0;
        chk("done_pulse", bus.done, 1'b1);
        chk("busy_after", bus.busy, 1'b0);
        chk("valid_after", bus.out_valid, 1'b0);
        if (mode == 0) chk("done_cycle", cyc, 2 + N);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_single", bus.done, 1'b0);
            chk("stay_idle", bus.busy, 1'b0);
        end
    endtask

    initial begin
        logic [PW-1:0] got;
        bus.ld_we = 1'b0; bus.ld_row = '0; bus.ld_col = '0;
        bus.ld_x = '0; bus.ld_y = '0; bus.ld_z = '0; bus.ld_is_ground = 1'b0;
        bus.start = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_valid", bus.out_valid, 1'b0);
        got = got_payload();
        chk("rst_payload", got, {PW{1'b0}});

        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                mx[r*COLS+c] = W'(r);
                my[r*COLS+c] = W'(c);
                mz[r*COLS+c] = W'(r * COLS + c);
                mg[r*COLS+c] = 1'(c & 1);
                load(r, c, W'(r), W'(c), W'(r * COLS + c), 1'(c & 1));
            end
        end

        // Out-of-range writes; (3,31) would alias cell (4,1) if not rejected.
        load(30, 5, 16'h7777, 16'h7777, 16'h7777, 1'b1);
        load(3, 31, 16'h7777, 16'h7777, 16'h7777, 1'b0);

        bus.out_ready = 1'b1;
        stream(0, -1, 1'b0);
        stream(1, -1, 1'b0);
        stream(0, 417, 1'b0);
        stream(0, -1, 1'b0);
        stream(0, -1, 1'b1);

        mx[0] = 16'sd11; my[0] = 16'sd12; mz[0] = -16'sd100; mg[0] = 1'b0;
        mx[1] = 16'sd21; my[1] = 16'sd22; mz[1] = -16'sd99;  mg[1] = 1'b1;
        load(0, 0, mx[0], my[0], mz[0], mg[0]);
        load(0, 1, mx[1], my[1], mz[1], mg[1]);
        bus.out_ready = 1'b1;
        stream(0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
